gf180mcu_fd_sc_mcu9t5v0__arb3_rr: RTL and testbench

Three-requester round-robin arbiter macro that shares a single downstream resource among requesters A1/A2/A3. Its request-side pin naming and idle output follow the nor3 cell.
- Grants are registered, one-hot and break-before-make, with a guaranteed one-cycle dead gap between owners.
- An optional hold timeout prevents a requester from monopolising the resource.
- Used in the characterisation/test macro area wherever a shared scan or measurement resource needs sequencing.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__arb3_rr.sv | 162 ++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__arb3_rr.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arb3_rr.sv
// Three-requester round-robin arbiter with registered, one-hot, break-before-make grants.
// Latency: request sampled at edge n -> grant visible after edge n (1 cycle); one dead cycle between owners.
// Backpressure: owner holds grant while its request stays high; EN=0 or hold timeout forces release.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   EN                arbitration enable; low releases the current grant and blocks new ones
//   A1, A2, A3        requests
//   Z1, Z2, Z3        registered one-hot grants
//   ZN                combinational NOR of the requests (idle indicator)
//   BUSY              registered, high while a grant is held
//   TO                registered one-cycle pulse when a grant is revoked purely by timeout
module gf180mcu_fd_sc_mcu9t5v0__arb3_rr #(
   parameter int TIMEOUT = 15,
   parameter int CW      = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   input  logic A1,
   input  logic A2,
   input  logic A3,
   output logic Z1,
   output logic Z2,
   output logic Z3,
   output logic ZN,
   output logic BUSY,
   output logic TO
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   // Counter value seen in the last permitted grant cycle (counter starts at 0 on the grant edge).
   localparam logic [CW-1:0] C_TLIM = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] C_SAT  = '1;

   state_t        r_state, w_state;
   logic [1:0]    r_owner, w_owner;   // 1..3 while granted
   logic [1:0]    r_last,  w_last;    // most recent owner, 1..3
   logic [CW-1:0] r_cnt,   w_cnt;
   logic [2:0]    r_z,     w_z;       // bit 0 = Z1
   logic          r_busy,  w_busy;
   logic          r_to,    w_to;

   logic [2:0]    w_req;
   logic          w_any;
   logic [1:0]    w_win;
   logic          w_own_req;
   logic          w_tmo;

   assign w_req = {A3, A2, A1};
   assign w_any = |w_req;

   // Rotating priority: scan starting just after the last owner.
   always_comb begin
      w_win = 2'd0;
      case (r_last)
         2'd1: begin
            if      (A2) w_win = 2'd2;
            else if (A3) w_win = 2'd3;
            else if (A1) w_win = 2'd1;
         end
         2'd2: begin
            if      (A3) w_win = 2'd3;
            else if (A1) w_win = 2'd1;
            else if (A2) w_win = 2'd2;
         end
         default: begin
            if      (A1) w_win = 2'd1;
            else if (A2) w_win = 2'd2;
            else if (A3) w_win = 2'd3;
         end
      endcase
   end

   always_comb begin
      w_own_req = 1'b0;
      case (r_owner)
         2'd1:    w_own_req = A1;
         2'd2:    w_own_req = A2;
         2'd3:    w_own_req = A3;
         default: w_own_req = 1'b0;
      endcase
   end

   assign w_tmo = (TIMEOUT != 0) && (r_cnt == C_TLIM);

   // Next-state and registered-output logic.
   always_comb begin
      w_state = r_state;
      w_owner = r_owner;
      w_last  = r_last;
      w_cnt   = r_cnt;
      w_z     = r_z;
      w_busy  = r_busy;
      w_to    = 1'b0;
      case (r_state)
         S_GRANT: begin
            if (!w_own_req || !EN || w_tmo) begin
               w_state = S_GAP;
               w_z     = 3'b000;
               w_busy  = 1'b0;
               w_last  = r_owner;
               // Pulse only when the timeout is the sole reason for release.
               w_to    = w_tmo && w_own_req && EN;
            end else if (r_cnt != C_SAT) begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         default: begin
            // IDLE and GAP arbitrate identically; GAP itself guarantees the dead cycle.
            if (EN && w_any) begin
               w_state = S_GRANT;
               w_owner = w_win;
               w_cnt   = '0;
               w_busy  = 1'b1;
               case (w_win)
                  2'd1:    w_z = 3'b001;
                  2'd2:    w_z = 3'b010;
                  default: w_z = 3'b100;
               endcase
            end else begin
               w_state = S_IDLE;
               w_z     = 3'b000;
               w_busy  = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_owner <= 2'd0;
         r_last  <= 2'd3;
         r_cnt   <= '0;
         r_z     <= 3'b000;
         r_busy  <= 1'b0;
         r_to    <= 1'b0;
      end else begin
         r_state <= w_state;
         r_owner <= w_owner;
         r_last  <= w_last;
         r_cnt   <= w_cnt;
         r_z     <= w_z;
         r_busy  <= w_busy;
         r_to    <= w_to;
      end
   end

   assign Z1   = r_z[0];
   assign Z2   = r_z[1];
   assign Z3   = r_z[2];
   assign BUSY = r_busy;
   assign TO   = r_to;
   assign ZN   = ~(A1 | A2 | A3);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__arb3_rr.sv
module tb_gf180mcu_fd_sc_mcu9t5v0__arb3_rr;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic a1  = 1'b0;
   logic a2  = 1'b0;
   logic a3  = 1'b0;

   logic z1_0, z2_0, z3_0, zn_0, busy_0, to_0;   // TIMEOUT=15 instance
   logic z1_1, z2_1, z3_1, zn_1, busy_1, to_1;   // TIMEOUT=0 instance

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   gf180mcu_fd_sc_mcu9t5v0__arb3_rr #(.TIMEOUT(15), .CW(4)) dut (
      .CLK(clk), .RST(rst), .EN(en), .A1(a1), .A2(a2), .A3(a3),
      .Z1(z1_0), .Z2(z2_0), .Z3(z3_0), .ZN(zn_0), .BUSY(busy_0), .TO(to_0)
   );

   gf180mcu_fd_sc_mcu9t5v0__arb3_rr #(.TIMEOUT(0), .CW(4)) dut0 (
      .CLK(clk), .RST(rst), .EN(en), .A1(a1), .A2(a2), .A3(a3),
      .Z1(z1_1), .Z2(z2_1), .Z3(z3_1), .ZN(zn_1), .BUSY(busy_1), .TO(to_1)
   );

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Owner 0 means nobody holds the resource (idle or gap); held counts granted cycles.
   int m_owner [2];
   int m_last  [2];
   int m_held  [2];
   bit m_to    [2];
   logic [4:0] q0[$];
   logic [4:0] q1[$];

   function automatic logic [4:0] model_step(input int i, input int tmo,
                                             input logic e, input logic [3:1] rq);
      bit found;
      m_to[i] = 1'b0;
      if (m_owner[i] != 0) begin
         bit own = rq[m_owner[i]];
         bit tm  = (tmo != 0) && (m_held[i] == tmo);
         if (!own || !e || tm) begin
            m_to[i]    = tm && own && e;
            m_last[i]  = m_owner[i];
            m_owner[i] = 0;
         end else begin
            m_held[i]++;
         end
      end else if (e && (rq != 3'b000)) begin
         found = 1'b0;
         for (int s = 1; s <= 3; s++) begin
            int k = (m_last[i] + s - 1) % 3 + 1;
            if (!found && rq[k]) begin
               found      = 1'b1;
               m_owner[i] = k;
               m_held[i]  = 1;
            end
         end
      end
      return {m_owner[i] == 3, m_owner[i] == 2, m_owner[i] == 1, m_owner[i] != 0, m_to[i]};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_owner[i] = 0;
            m_last[i]  = 3;
            m_held[i]  = 0;
            m_to[i]    = 1'b0;
         end
         q0.delete();
         q1.delete();
      end else begin
         q0.push_back(model_step(0, 15, en, {a3, a2, a1}));
         q1.push_back(model_step(1, 0,  en, {a3, a2, a1}));
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (q0.size() > 0) chk("dut_t15", {z3_0, z2_0, z1_0, busy_0, to_0}, q0.pop_front());
         if (q1.size() > 0) chk("dut_t0",  {z3_1, z2_1, z1_1, busy_1, to_1}, q1.pop_front());
         chk("zn", {3'b000, zn_0, zn_1}, {3'b000, ~(a1 | a2 | a3), ~(a1 | a2 | a3)});
         chk("busy_inv", {3'b000, busy_0, busy_1}, {3'b000, z1_0 | z2_0 | z3_0, z1_1 | z2_1 | z3_1});
      end
   end

   // Inputs change 1 time unit after the falling edge, clear of both sampling points.
   task automatic drive(input logic e, input logic [2:0] rq, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         #1;
         en = e;
         {a3, a2, a1} = rq;
      end
   endtask

   initial begin
      logic [2:0] r;
      logic       e;

      // Reset values and ZN over all request combinations while in reset.
      #2;
      chk("rst_outs", {z3_0, z2_0, z1_0, busy_0, to_0}, 5'b00000);
      for (int i = 0; i < 8; i++) begin
         r = i[2:0];
         {a3, a2, a1} = r;
         #1;
         chk("zn_rst", {3'b000, zn_0, zn_1}, {3'b000, r == 3'b000, r == 3'b000});
      end
      {a3, a2, a1} = 3'b000;
      @(posedge clk);
      #2 rst = 1'b0;

      // All three requesting: rotation with 15-cycle holds, timeout pulses, dead cycles.
      drive(1'b1, 3'b111, 70);
      drive(1'b1, 3'b000, 3);

      // A2 alone for 5 cycles, then A1&A3 should go to A3 first.
      drive(1'b1, 3'b010, 5);
      drive(1'b1, 3'b000, 3);
      drive(1'b1, 3'b101, 4);
      drive(1'b1, 3'b000, 3);

      // EN dropped mid-grant with A1 held.
      drive(1'b1, 3'b001, 4);
      drive(1'b0, 3'b001, 5);
      drive(1'b1, 3'b001, 4);
      drive(1'b1, 3'b000, 3);

      // Asynchronous reset while Z3 is held.
      drive(1'b1, 3'b100, 3);
      @(posedge clk);
      #1;
      chk("pre_rst_z3", {z3_0, z2_0, z1_0, busy_0, to_0}, 5'b10010);
      #1 rst = 1'b1;
      #1;
      chk("async_rst", {z3_0, z2_0, z1_0, busy_0, to_0}, 5'b00000);
      chk("async_rst0", {z3_1, z2_1, z1_1, busy_1, to_1}, 5'b00000);
      @(posedge clk);
      #2 rst = 1'b0;
      drive(1'b1, 3'b101, 4);
      drive(1'b1, 3'b000, 3);

      // A1 held 100 cycles with A2 pending; the TIMEOUT=0 instance never releases.
      drive(1'b1, 3'b011, 100);
      drive(1'b1, 3'b010, 4);
      drive(1'b1, 3'b000, 3);

      // Randomised traffic with sticky requests and occasional EN drops.
      r = 3'b000;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
         e = ($urandom_range(0, 19) != 0);
         drive(e, r, 1);
      end
      drive(1'b1, 3'b000, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
